// File: rtl/rr_grant_decoder_arb_if.sv
// Request/grant bundle between four masters and the round-robin arbiter.
`default_nettype none

interface rr_grant_decoder_arb_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  modport master (output req, input gnt, input gnt_idx, input gnt_valid);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid);
endinterface

`default_nettype wire

// File: rtl/rr_grant_decoder_arb.sv
// Four-requester round-robin arbiter: registered grant index decoded to a one-hot
// grant, bounded tenure with a single idle turnaround cycle between owners.
`default_nettype none

module rr_grant_decoder_arb #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_grant_decoder_arb_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_HANDOFF = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam bit               PREEMPT  = (MAX_HOLD != 0);

  function automatic logic [3:0] decode2to4(input logic [1:0] idx);
    decode2to4 = 4'b0001 << idx;
  endfunction

  logic [1:0]       state;
  logic [1:0]       last;
  logic [1:0]       gnt_idx_q;
  logic             gnt_valid_q;
  logic [CNT_W-1:0] hold_cnt;

  logic [3:0] owner_dec;
  logic [1:0] win_idx;
  logic       win_found;
  logic [1:0] cand;
  logic       rel_drop;
  logic       rel_tenure;
  logic       hold_at_cap;

  assign owner_dec = decode2to4(gnt_idx_q);

  // Scan starts one past the last winner so every requester gets its turn.
  always_comb begin
    win_idx   = last;
    win_found = 1'b0;
    cand      = last;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign rel_drop    = !bus.req[gnt_idx_q];
  assign rel_tenure  = PREEMPT && (hold_cnt >= HOLD_MAX) && ((bus.req & ~owner_dec) != 4'b0000);
  // Without preemption the counter only needs to avoid wrapping.
  assign hold_at_cap = PREEMPT ? (hold_cnt >= HOLD_MAX) : (&hold_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last        <= 2'd3;
      gnt_idx_q   <= 2'd0;
      gnt_valid_q <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_HANDOFF: begin
          if (win_found) begin
            state       <= S_BUSY;
            gnt_idx_q   <= win_idx;
            gnt_valid_q <= 1'b1;
            last        <= win_idx;
            hold_cnt    <= CNT_W'(1);
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (rel_drop || rel_tenure) begin
            state       <= S_HANDOFF;
            gnt_valid_q <= 1'b0;
          end else if (!hold_at_cap) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state       <= S_IDLE;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = owner_dec & {4{gnt_valid_q}};
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_decoder_arb.sv
// Scoreboard bench: a rotation-based reference model queues the expected grant
// per edge; a negedge monitor compares it with the DUT outputs.
`default_nettype none

module tb_rr_grant_decoder_arb;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rr_grant_decoder_arb_if bus ();

  rr_grant_decoder_arb #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: who owns the resource, who won last, how long the owner has held.
  int m_owner;
  int m_last;
  int m_idx;
  int m_tenure;

  function void model_reset();
    m_owner  = -1;
    m_last   = 3;
    m_idx    = 0;
    m_tenure = 0;
  endfunction

  function void model_step(input logic [3:0] r);
    logic [3:0] others;
    if (m_owner >= 0) begin
      others = r & ~(4'b0001 << m_owner);
      if (!r[m_owner] || (MAX_HOLD != 0 && m_tenure >= MAX_HOLD && others != 4'b0000))
        m_owner = -1;
      else
        m_tenure = m_tenure + 1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        if (m_owner < 0 && r[(m_last + k) % 4]) begin
          m_owner  = (m_last + k) % 4;
          m_last   = m_owner;
          m_idx    = m_owner;
          m_tenure = 1;
        end
      end
    end
  endfunction

  function exp_t model_out();
    exp_t e;
    e.gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.idx   = 2'(m_idx);
    e.valid = (m_owner >= 0);
    return e;
  endfunction

  // One clock edge: model the edge with the request that was present, then drive the next one.
  task automatic tick(input logic [3:0] next_req);
    @(posedge clk);
    #1;
    model_step(bus.req);
    sb.push_back(model_out());
    bus.req = next_req;
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 2'b00) begin
      fails++;
      $display("FAIL %s: got gnt=%b idx=%b valid=%b, expected gnt=0000 idx=00 valid=0",
               name, bus.gnt, bus.gnt_idx, bus.gnt_valid);
    end
  endtask

  // Called at posedge+1; asserts reset mid-cycle and checks outputs before the next edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (rst_n && sb.size() > 0) begin
        e   = sb.pop_front();
        act = {bus.gnt, bus.gnt_idx, bus.gnt_valid};
        tests++;
        if (act !== e) begin
          fails++;
          $display("FAIL grant_state @%0t: got gnt=%b idx=%0d valid=%b, expected gnt=%b idx=%0d valid=%b",
                   $time, bus.gnt, bus.gnt_idx, bus.gnt_valid, e.gnt, e.idx, e.valid);
        end
        tests++;
        if ((bus.gnt & (bus.gnt - 4'd1)) != 4'b0000) begin
          fails++;
          $display("FAIL onehot @%0t: got gnt=%b, expected at most one bit set", $time, bus.gnt);
        end
      end
    end
  end

  initial begin : driver
    logic [3:0] r;
    bus.req = 4'b0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("power_on_reset");
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Single requester: grant for three edges, then HANDOFF and IDLE.
    tick(4'b0001);
    tick(4'b0001);
    tick(4'b0001);
    tick(4'b0000);
    tick(4'b0000);
    repeat (3) tick(4'b0000);

    // Reset while a grant is active.
    tick(4'b0010);
    tick(4'b0010);
    tick(4'b0010);
    async_reset();

    // All four requesting: rotation with bounded tenure.
    bus.req = 4'b1111;
    repeat (24) tick(4'b1111);
    tick(4'b0000);
    async_reset();

    // Sole requester is never preempted.
    bus.req = 4'b0100;
    repeat (20) tick(4'b0100);
    tick(4'b0110);
    repeat (6) tick(4'b0110);
    async_reset();

    // Owner 1 drops its request exactly when its tenure expires.
    bus.req = 4'b0010;
    repeat (4) tick(4'b0010);
    tick(4'b1101);
    repeat (4) tick(4'b1101);
    async_reset();

    // Pointer rotation from 0 after reset.
    bus.req = 4'b1001;
    tick(4'b1001);
    tick(4'b1001);
    tick(4'b1000);
    repeat (4) tick(4'b1000);
    tick(4'b0000);
    async_reset();

    // Randomized traffic with sticky requests and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      r = bus.req;
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      tick(r);
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    tick(4'b0000);
    tick(4'b0000);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
